sudoku_ram_arbiter: RTL
=======================

SUDOKU_RAM_ARBITER -- requirements
Module: sudoku_ram_arbiter

Interface
REQ-001 Parameter N_CELLS, default 81, number of grid cells copied and addressable (addresses 0..N_CELLS-1).
REQ-002 Parameter DW, default 8, data width of ROM, RAM and requester data.
REQ-003 Parameter AW, default 7, address width of ROM, RAM and requester addresses.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that begins the ROM-to-RAM load.
REQ-007 ROM_rd  out  1  ROM read strobe; ROM_Q is valid the cycle after ROM_rd is sampled high.
REQ-008 ROM_A  out  AW  ROM read address.
REQ-009 ROM_Q  in  DW  ROM read data.
REQ-010 RAM_ceb  out  1  RAM chip enable, active-low.
REQ-011 RAM_web  out  1  RAM write enable, active-low; 1 = read.
REQ-012 RAM_A, RAM_D  out  AW, DW  RAM address and write data.
REQ-013 RAM_Q  in  DW  RAM read data, valid the cycle after a read access.
REQ-014 load_done  out  1  high from load completion until reset.
REQ-015 reqN, weN, addrN[AW-1:0], wdN[DW-1:0]  in  requester N (N=0 solver, N=1 checker) access request.
REQ-016 gntN  out  1  combinational grant to requester N, same cycle as the accepted request.
REQ-017 rvalidN  out  1  one-cycle pulse carrying read data for requester N on rdata.
REQ-018 rdata  out  DW  shared read-return data, meaningful only when some rvalidN is high.

Function
REQ-019 FSM states: IDLE, LOAD, SERVE; reset state IDLE.
REQ-020 IDLE: start=1 -> LOAD with load counter cleared to 0; start ignored in LOAD and SERVE.
REQ-021 LOAD issue: ROM_rd=1, ROM_A=counter for counter 0..N_CELLS-1; counter increments by 1 per cycle.
REQ-022 LOAD write: the cycle after issuing address k, RAM_ceb=0, RAM_web=0, RAM_A=k, RAM_D=ROM_Q (one-stage pipeline, one cell per cycle).
REQ-023 LOAD lasts exactly N_CELLS+1 cycles; the last write (address N_CELLS-1) occurs in the final LOAD cycle; next cycle state=SERVE and load_done=1.
REQ-024 gnt0, gnt1 are 0 and requests are ignored (not queued) in IDLE and LOAD.
REQ-025 SERVE: at most one grant per cycle; a single requesting port is granted immediately.
REQ-026 SERVE, both requesting: round-robin; grant goes to the port not granted most recently; priority pointer resets to favour port 0.
REQ-027 Granted access with addr < N_CELLS: RAM_ceb=0, RAM_web=~weN, RAM_A=addrN, RAM_D=wdN.
REQ-028 Granted read: next cycle rvalidN=1, rdata=RAM_Q; a new grant may be issued in the same cycle (full throughput, one access/cycle).
REQ-029 Granted access with addr >= N_CELLS: gnt still asserted, RAM_ceb stays 1; a read returns rvalidN=1 with rdata=0 next cycle; a write is dropped.
REQ-030 No RAM access in any cycle without a LOAD write or a grant: RAM_ceb=1, RAM_web=1.
REQ-031 rvalid0 and rvalid1 are never high in the same cycle.

Reset
REQ-032 rst=1 asynchronously forces: state IDLE, counter 0, ROM_rd=0, ROM_A=0, RAM_ceb=1, RAM_web=1, RAM_A=0, RAM_D=0, load_done=0, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, pointer favours port 0.
REQ-033 Reset asserted mid-LOAD or mid-SERVE aborts the operation; any pending rvalid is discarded; a new start pulse is required after release.

Verification
REQ-034 ROM filled with value 8'h10+addr, start pulse -> 81 writes to RAM addresses 0..80 on consecutive cycles, RAM_M[k]=8'h10+k, load_done rises 82 cycles after the start edge.
REQ-035 In SERVE, req0 read addr 5 alone -> gnt0 same cycle, rvalid0=1 and rdata=8'h15 next cycle, gnt1 and rvalid1 stay 0.
REQ-036 req0 and req1 held high for 4 cycles (reads addr 0 and 1) -> grants alternate 0,1,0,1; rvalid pulses alternate with rdata 8'h10,8'h11,8'h10,8'h11.
REQ-037 req1 write addr 90 data 8'hAA, then read addr 90 -> RAM_ceb stays 1 throughout, RAM contents unchanged, rvalid1 with rdata=8'h00.
REQ-038 rst asserted at load counter 40 -> all outputs at reset values immediately, RAM addresses 40..80 untouched, req0 ignored until a new start completes the load.
REQ-039 start pulsed during SERVE and req0 asserted during LOAD -> no state change from start, no gnt0 during LOAD.

Source files
------------

// File: rtl/sudoku_ram_arbiter.sv
// sudoku_ram_arbiter: copies an N_CELLS-entry grid from ROM into a single-port
// RAM, then shares that RAM between a solver (port 0) and a checker (port 1)
// with round-robin arbitration. One RAM access per cycle. Read data comes back
// on a shared rdata bus, qualified by a one-cycle rvalidN pulse.
module sudoku_ram_arbiter #(
    parameter int N_CELLS = 81,
    parameter int DW      = 8,
    parameter int AW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    // ROM side
    output logic          ROM_rd,
    output logic [AW-1:0] ROM_A,
    input  logic [DW-1:0] ROM_Q,
    // RAM side
    output logic          RAM_ceb,
    output logic          RAM_web,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_D,
    input  logic [DW-1:0] RAM_Q,
    output logic          load_done,
    // requester 0 (solver)
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wd0,
    output logic          gnt0,
    output logic          rvalid0,
    // requester 1 (checker)
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wd1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata
);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

    // One extra bit so the counter can hold N_CELLS itself (the final write-only cycle).
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  LAST = CW'(N_CELLS);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ptr;          // 1 = port 1 has priority on the next conflict
    logic          rd_in_range;  // the read returning this cycle hit real RAM
    logic          load_issue;
    logic          load_write;
    logic          in_range0;
    logic          in_range1;
    logic [AW-1:0] load_wr_addr;

    // Load sequencer: IDLE -> LOAD (N_CELLS+1 cycles) -> SERVE until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            load_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (cnt == LAST) begin
                        state     <= SERVE;
                        load_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SERVE:   ;
                default: state <= IDLE;
            endcase
        end
    end

    // ROM issue runs for counter 0..N_CELLS-1; the RAM write trails it by one
    // cycle because ROM_Q only becomes valid the cycle after the read strobe.
    assign load_issue   = (state == LOAD) && (cnt != LAST);
    assign load_write   = (state == LOAD) && (cnt != '0);
    assign load_wr_addr = cnt[AW-1:0] - AW'(1);
    assign ROM_rd       = load_issue;
    assign ROM_A        = load_issue ? cnt[AW-1:0] : '0;

    // Requests are only honoured once the grid has been loaded.
    assign in_range0 = {1'b0, addr0} < LAST;
    assign in_range1 = {1'b0, addr1} < LAST;
    assign gnt0      = (state == SERVE) && req0 && (!req1 || !ptr);
    assign gnt1      = (state == SERVE) && req1 && (!req0 ||  ptr);

    // RAM port mux: load write, granted in-range access, or idle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        RAM_ceb = 1'b1;
        RAM_web = 1'b1;
        RAM_A   = '0;
        RAM_D   = '0;
        if (load_write) begin
            RAM_ceb = 1'b0;
            RAM_web = 1'b0;
            RAM_A   = load_wr_addr;
            RAM_D   = ROM_Q;
        end else if (gnt0 && in_range0) begin
            RAM_ceb = 1'b0;
            RAM_web = ~we0;
            RAM_A   = addr0;
            RAM_D   = wd0;
        end else if (gnt1 && in_range1) begin
            RAM_ceb = 1'b0;
            RAM_web = ~we1;
            RAM_A   = addr1;
            RAM_D   = wd1;
        end
    end

    // Read-return tracking and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rd_in_range <= 1'b0;
            ptr         <= 1'b0;
        end else begin
            rvalid0     <= gnt0 && !we0;
            rvalid1     <= gnt1 && !we1;
            rd_in_range <= gnt0 ? in_range0 : in_range1;
            if (gnt0) ptr <= 1'b1;
            else if (gnt1) ptr <= 1'b0;
        end
    end

    // Out-of-range reads never touched the RAM, so they return zero.
    assign rdata = ((rvalid0 || rvalid1) && rd_in_range) ? RAM_Q : '0;

endmodule
